prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Multi-cycle fetch/execute controller for the single-cycle-decoded core.
- Owns the program counter.
- Gates the control decoder's RegWrite/MemWrite so that each one fires exactly once per instruction.
- Inserts a write-back cycle for loads.
- Resolves branches through the branch-target LUT (how_high index).
- Provides the Start/Done handshake to the test harness.

Parameters:
- PC_W, 10, program counter width; the PC wraps modulo 2^PC_W.
- LUT_W, 2, width of the branch LUT index (how_high).
- START_PC, 0, PC value loaded on reset and on every start.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin program; sampled in IDLE and HALT only.
- halt  in  1  decoder: current instruction is the done/halt opcode.
- branch  in  1  decoder branch output.
- taken  in  1  ALU branch condition (e.g. zero flag).
- how_high  in  LUT_W  decoder LUT index.
- lut_target  in  PC_W  target address returned by the LUT for lut_idx.
- mem_to_reg  in  1  decoder MemtoReg (load).
- mem_write  in  1  decoder MemWrite (store).
- lut_idx  out  LUT_W  LUT address; always equals how_high (combinational).
- pc  out  PC_W  instruction memory address.
- instr_valid  out  1  instruction register capture enable.
- reg_we_gate  out  1  ANDed with RegWrite at the register file.
- mem_we_gate  out  1  ANDed with MemWrite at data memory.
- busy  out  1  program executing.
- done  out  1  program finished; held until the next start.

Behaviour:
- States: IDLE, FETCH, EXEC, LOAD_WB, HALT. State, pc and done are registered.
- Gate outputs are combinational from state plus the decoder inputs.
- Reset asserted, at any time including mid-instruction:
  - state=IDLE, pc=START_PC, done=0.
  - instr_valid, reg_we_gate, mem_we_gate and busy are 0 immediately, without waiting for Clk.
- busy=1 in FETCH, EXEC and LOAD_WB; busy=0 in IDLE and HALT.
- IDLE:
  - All gates 0.
  - start=1 -> FETCH, pc<=START_PC.
- FETCH:
  - instr_valid=1; the instruction register captures imem[pc] at the end of the cycle.
  - Always -> EXEC. pc unchanged.
- EXEC, priority order:
  1. halt=1 -> HALT; done<=1; all gates 0; pc unchanged.
  2. mem_to_reg=1 (load) -> LOAD_WB; reg_we_gate=0, mem_we_gate=0; pc unchanged. branch is ignored.
  3. Otherwise:
     - reg_we_gate=1; mem_we_gate=mem_write.
     - pc <= lut_target if (branch & taken), else pc+1.
     - -> FETCH.
- LOAD_WB:
  - reg_we_gate=1, mem_we_gate=0.
  - pc <= pc+1; -> FETCH.
- HALT:
  - done=1, gates 0.
  - start=1 -> FETCH with pc<=START_PC; done<=0 on the same edge.
- Timing: ALU/store/branch instructions take 2 cycles; loads take 3 cycles. No other latency.
- pc+1 at 2^PC_W-1 wraps to 0; no flag is raised.
- start while busy is ignored.
- start held high across HALT restarts immediately, so done pulses for 1 cycle only.
- A branch target equal to the current pc is legal; it forms a spin loop until reset.
- X on the decoder inputs in IDLE, FETCH or HALT must not affect state or gates.

Test Plan:
1. Reset=0 for 2 cycles, then 1; start pulse -> pc=0. FETCH at cycle 1 (instr_valid=1), EXEC at cycle 2. Add at pc 0 -> reg_we_gate=1 for exactly 1 cycle, then pc=1.
2. Store at pc 3 (mem_write=1) -> mem_we_gate=1 for exactly 1 cycle, reg_we_gate gated by the decoder's RegWrite=0, pc=4 two cycles after fetch.
3. Load at pc 5 -> EXEC has both gates 0; LOAD_WB has reg_we_gate=1; pc=6 three cycles after the FETCH of pc 5.
4. Branch, how_high=2, lut_target=0x1F0:
   - taken=1 -> lut_idx=2, pc=0x1F0.
   - taken=0 -> pc=pc+1.
   - Program pc at 0x3FF with a non-branch -> pc wraps to 0.
5. halt at pc 8 -> done=1 and busy=0 the next cycle, pc stays 8. start pulse -> done=0, pc=0, FETCH.
6. Drop Reset mid-LOAD_WB -> reg_we_gate falls before the next Clk edge. After release, state=IDLE, pc=0, start while busy has no effect.

Source files
------------

// File: rtl/prog_sequencer.sv
// Multi-cycle fetch/execute controller: owns the PC, gates RegWrite/MemWrite once per instruction.
// ALU/store/branch take FETCH+EXEC (2 cycles); loads add LOAD_WB (3 cycles); Start/Done handshake.
module prog_sequencer #(
  parameter int unsigned PC_W              = 10,
  parameter int unsigned LUT_W             = 2,
  parameter logic [PC_W-1:0] START_PC      = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             halt,
  input  logic             branch,
  input  logic             taken,
  input  logic [LUT_W-1:0] how_high,
  input  logic [PC_W-1:0]  lut_target,
  input  logic             mem_to_reg,
  input  logic             mem_write,
  output logic [LUT_W-1:0] lut_idx,
  output logic [PC_W-1:0]  pc,
  output logic             instr_valid,
  output logic             reg_we_gate,
  output logic             mem_we_gate,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_LOAD_WB = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // Decoder inputs are only looked at in EXEC so X elsewhere cannot leak into state or gates.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    done_d      = done_q;
    instr_valid = 1'b0;
    reg_we_gate = 1'b0;
    mem_we_gate = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = START_PC;
        end
      end
      S_FETCH: begin
        instr_valid = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        if (halt) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (mem_to_reg) begin
          state_d = S_LOAD_WB;
        end else begin
          reg_we_gate = 1'b1;
          mem_we_gate = mem_write;
          pc_d        = (branch && taken) ? lut_target : pc_q + PC_W'(1);
          state_d     = S_FETCH;
        end
      end
      S_LOAD_WB: begin
        reg_we_gate = 1'b1;
        pc_d        = pc_q + PC_W'(1);
        state_d     = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = START_PC;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_PC;
        done_d  = 1'b0;
      end
    endcase
  end

  assign lut_idx = how_high;
  assign pc      = pc_q;
  assign done    = done_q;
  assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_LOAD_WB);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: hand-computed PC/gate/handshake values checked with immediate assertions.
module tb_prog_sequencer;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic       halt;
  logic       branch;
  logic       taken;
  logic [1:0] how_high;
  logic [9:0] lut_target;
  logic       mem_to_reg;
  logic       mem_write;
  logic [1:0] lut_idx;
  logic [9:0] pc;
  logic       instr_valid;
  logic       reg_we_gate;
  logic       mem_we_gate;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  prog_sequencer #(.PC_W(10), .LUT_W(2), .START_PC(10'd0)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .halt        (halt),
    .branch      (branch),
    .taken       (taken),
    .how_high    (how_high),
    .lut_target  (lut_target),
    .mem_to_reg  (mem_to_reg),
    .mem_write   (mem_write),
    .lut_idx     (lut_idx),
    .pc          (pc),
    .instr_valid (instr_valid),
    .reg_we_gate (reg_we_gate),
    .mem_we_gate (mem_we_gate),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic dec_clear();
    halt = 1'b0; branch = 1'b0; taken = 1'b0; how_high = 2'd0;
    lut_target = 10'd0; mem_to_reg = 1'b0; mem_write = 1'b0;
  endtask

  task automatic dec_x();
    halt = 1'bx; branch = 1'bx; taken = 1'bx; how_high = 2'bxx;
    lut_target = 'x; mem_to_reg = 1'bx; mem_write = 1'bx;
  endtask

  // EXEC of a plain ALU op followed by the next FETCH.
  task automatic alu_pass();
    tick(); dec_clear();
    tick(); dec_x();
  endtask

  // EXEC of a taken branch to tgt, ending in the FETCH of tgt.
  task automatic take_branch(input logic [9:0] tgt);
    tick(); dec_clear(); branch = 1'b1; taken = 1'b1; lut_target = tgt;
    tick(); dec_x();
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; dec_clear();
    #2;
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_iv", instr_valid, 0);
    chk("rst_reg", reg_we_gate, 0);
    chk("rst_mem", mem_we_gate, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Start, then add at pc 0
    start = 1'b1;
    tick(); start = 1'b0; dec_x(); #1;
    chk("fetch0_iv", instr_valid, 1);
    chk("fetch0_pc", pc, 0);
    chk("fetch0_busy", busy, 1);
    chk("fetch0_reg", reg_we_gate, 0);
    tick(); dec_clear(); #1;
    chk("add_reg", reg_we_gate, 1);
    chk("add_mem", mem_we_gate, 0);
    chk("add_iv", instr_valid, 0);
    tick(); dec_x(); #1;
    chk("add_pc_next", pc, 1);
    chk("add_reg_once", reg_we_gate, 0);

    alu_pass();
    alu_pass();
    chk("pc3", pc, 3);

    // Store at pc 3
    tick(); dec_clear(); mem_write = 1'b1; #1;
    chk("st_mem", mem_we_gate, 1);
    chk("st_reg", reg_we_gate, 1);
    tick(); #1;
    chk("st_mem_once", mem_we_gate, 0);
    chk("st_pc", pc, 4);
    alu_pass();
    chk("pc5", pc, 5);

    // Load at pc 5, with branch asserted to confirm it is ignored
    tick(); dec_clear(); mem_to_reg = 1'b1; mem_write = 1'b1;
    branch = 1'b1; taken = 1'b1; lut_target = 10'h1F0; #1;
    chk("ld_exec_reg", reg_we_gate, 0);
    chk("ld_exec_mem", mem_we_gate, 0);
    chk("ld_exec_busy", busy, 1);
    tick(); #1;
    chk("ld_wb_reg", reg_we_gate, 1);
    chk("ld_wb_mem", mem_we_gate, 0);
    chk("ld_wb_pc", pc, 5);
    tick(); dec_x(); #1;
    chk("ld_pc", pc, 6);
    chk("ld_iv", instr_valid, 1);

    // Taken branch via LUT index 2
    tick(); dec_clear(); branch = 1'b1; taken = 1'b1; how_high = 2'd2; lut_target = 10'h1F0; #1;
    chk("br_lut_idx", lut_idx, 2);
    tick(); dec_x(); #1;
    chk("br_taken_pc", pc, 10'h1F0);

    // Not-taken branch
    tick(); dec_clear(); branch = 1'b1; taken = 1'b0; how_high = 2'd2; lut_target = 10'h1F0;
    tick(); dec_x(); #1;
    chk("br_nt_pc", pc, 10'h1F1);

    take_branch(10'h3FF);
    chk("pc_3ff", pc, 10'h3FF);
    alu_pass();
    chk("pc_wrap", pc, 0);
    take_branch(10'h000);
    chk("spin_pc", pc, 0);
    take_branch(10'h008);
    chk("pc8", pc, 8);

    // Halt at pc 8 wins over load/store
    tick(); dec_clear(); halt = 1'b1; mem_to_reg = 1'b1; mem_write = 1'b1; #1;
    chk("halt_reg", reg_we_gate, 0);
    chk("halt_mem", mem_we_gate, 0);
    tick(); dec_x(); #1;
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, 8);
    tick(); #1;
    chk("halt_hold_done", done, 1);
    chk("halt_hold_pc", pc, 8);
    chk("halt_hold_iv", instr_valid, 0);
    chk("halt_hold_reg", reg_we_gate, 0);

    start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("restart_done", done, 0);
    chk("restart_pc", pc, 0);
    chk("restart_iv", instr_valid, 1);

    // Reset dropped in the middle of LOAD_WB
    tick(); dec_clear(); mem_to_reg = 1'b1;
    tick(); #1;
    chk("ld2_wb_reg", reg_we_gate, 1);
    #1 Reset = 1'b0;
    #1;
    chk("arst_reg", reg_we_gate, 0);
    chk("arst_busy", busy, 0);
    chk("arst_iv", instr_valid, 0);
    chk("arst_pc", pc, 0);
    dec_clear();
    @(negedge Clk) Reset = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_pc", pc, 0);

    // start held while busy is ignored, then held across HALT restarts at once
    start = 1'b1;
    tick(); #1;
    chk("hold_fetch_iv", instr_valid, 1);
    tick(); dec_clear();
    tick(); #1;
    chk("busy_start_pc", pc, 1);
    chk("busy_start_busy", busy, 1);
    tick(); dec_clear(); halt = 1'b1;
    tick(); dec_clear(); #1;
    chk("held_halt_done", done, 1);
    chk("held_halt_busy", busy, 0);
    tick(); #1;
    chk("held_restart_done", done, 0);
    chk("held_restart_pc", pc, 0);
    chk("held_restart_iv", instr_valid, 1);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
